seq_mul_4bit: RTL and testbench



---
 rtl/seq_mul_4bit.sv | 104 ++++++++++
 tb/tb_seq_mul_4bit.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/seq_mul_4bit.sv
// Sequential shift-add unsigned multiplier with a start/done handshake.
// Computes the product over W RUN cycles; product stays registered for the display.
module seq_mul_4bit #(
  parameter int W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic             busy,
  output logic             done,
  output logic [2*W-1:0]   product
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [2*W-1:0]   mcand;
  logic [2*W-1:0]   acc;
  logic [2*W-1:0]   acc_sum;
  logic [W-1:0]     mplier;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             last_step;

  // DONE accepts a new start just like IDLE, which gives back-to-back operation.
  always_comb begin
    accept    = 1'b0;
    last_step = 1'b0;
    acc_sum   = acc;
    state_nxt = state;
    if (mplier[0]) begin
      acc_sum = acc + mcand;
    end
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (cnt == LAST) begin
          last_step = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // product is written only on the final RUN edge so partial sums never reach the display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
    end else if (accept) begin
      mcand  <= {{W{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == RUN) begin
      acc    <= acc_sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (last_step) begin
        product <= acc_sum;
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_seq_mul_4bit.sv
// Directed bench for seq_mul_4bit (W=4): handshake timing, hold behaviour,
// ignored starts, back-to-back operation, async reset abort and a full operand sweep.
module tb_seq_mul_4bit;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] a_in;
  logic [3:0] b_in;
  logic       busy;
  logic       done;
  logic [7:0] product;

  int compared   = 0;
  int mismatched = 0;
  logic [7:0] last_product;

  seq_mul_4bit #(.W(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a_in),
    .b       (b_in),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One full operation: start for one cycle, then wait (bounded) for done.
  task automatic apply_stimulus(input logic [3:0] av, input logic [3:0] bv,
                                input string tag);
    int lat;
    logic [7:0] expected;
    expected = 8'(av) * 8'(bv);
    @(negedge clk);
    a_in  = av;
    b_in  = bv;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a_in  = ~av;
    b_in  = 4'($urandom_range(0, 15));
    lat   = 0;
    while (!done && lat < 12) begin
      check_output({tag, " busy"}, 32'(busy), 32'd1);
      check_output({tag, " hold"}, 32'(product), 32'(last_product));
      @(posedge clk); #1;
      lat++;
    end
    check_output({tag, " latency"}, 32'(lat), 32'd4);
    check_output({tag, " done"}, 32'(done), 32'd1);
    check_output({tag, " busy_in_done"}, 32'(busy), 32'd0);
    check_output({tag, " product"}, 32'(product), 32'(expected));
    last_product = expected;
    @(posedge clk); #1;
    check_output({tag, " done_drop"}, 32'(done), 32'd0);
    check_output({tag, " idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a_in  = 4'd0;
    b_in  = 4'd0;
    last_product = 8'h00;

    // Reset state
    #12;
    check_output("rst busy", 32'(busy), 32'd0);
    check_output("rst done", 32'(done), 32'd0);
    check_output("rst product", 32'(product), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_output("idle done", 32'(done), 32'd0);

    // Basic operations and hold-until-done
    apply_stimulus(4'd3, 4'd5, "mul3x5");
    apply_stimulus(4'd15, 4'd15, "mul15x15");
    apply_stimulus(4'd0, 4'd9, "mul0x9");
    apply_stimulus(4'd9, 4'd0, "mul9x0");

    // Start pulsed during the 2nd RUN cycle must be ignored
    @(negedge clk);
    a_in = 4'd2; b_in = 4'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; a_in = 4'd7; b_in = 4'd7;
    @(posedge clk); #1;
    start = 1'b0;
    check_output("ign busy2", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check_output("ign busy3", 32'(busy), 32'd1);
    check_output("ign nodone", 32'(done), 32'd0);
    @(posedge clk); #1;
    check_output("ign done", 32'(done), 32'd1);
    check_output("ign product", 32'(product), 32'h06);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check_output("ign single_pulse", 32'(done), 32'd0);
      check_output("ign idle", 32'(busy), 32'd0);
    end
    last_product = 8'h06;

    // Start held high: back-to-back results every 5 cycles
    @(negedge clk);
    a_in = 4'd4; b_in = 4'd4; start = 1'b1;
    @(posedge clk); #1;
    for (int i = 1; i <= 14; i++) begin
      @(posedge clk); #1;
      check_output("b2b done", 32'(done), (i % 5 == 4) ? 32'd1 : 32'd0);
      check_output("b2b busy", 32'(busy), (i % 5 == 4) ? 32'd0 : 32'd1);
      check_output("b2b product", 32'(product), (i < 4) ? 32'h06 : 32'h10);
    end
    start = 1'b0;
    @(posedge clk); #1;
    check_output("b2b idle busy", 32'(busy), 32'd0);
    check_output("b2b idle done", 32'(done), 32'd0);
    last_product = 8'h10;

    // Asynchronous reset in the 3rd RUN cycle of 9*9
    @(negedge clk);
    a_in = 4'd9; b_in = 4'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_output("abort pre busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("abort busy", 32'(busy), 32'd0);
    check_output("abort done", 32'(done), 32'd0);
    check_output("abort product", 32'(product), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check_output("abort no_done", 32'(done), 32'd0);
      check_output("abort no_busy", 32'(busy), 32'd0);
    end
    last_product = 8'h00;
    apply_stimulus(4'd9, 4'd9, "mul9x9");

    // Full operand sweep
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        apply_stimulus(4'(x), 4'(y), "sweep");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
